// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Both directions use valid/ready: a transfer happens on a rising edge where valid && ready.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero_flag;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, zero_flag
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, zero_flag
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider,
// one bit per clock, one operation in flight, sign handled outside the datapath.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  muldiv_if.slave    bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 zero_q, zero_d;

  // Operand decode at the accept edge.
  logic             a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             b_zero, sdiv_ovf, special;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
               (bus.op == 3'b100) || (bus.op == 3'b110);
    b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    sa       = a_signed & bus.a[WIDTH-1];
    sb       = b_signed & bus.b[WIDTH-1];
    a_mag    = sa ? (~bus.a + 1'b1) : bus.a;
    b_mag    = sb ? (~bus.b + 1'b1) : bus.b;
    b_zero   = bus.op[2] && (bus.b == '0);
    sdiv_ovf = bus.op[2] && !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == ALL_ONES);
    special  = b_zero || sdiv_ovf;
    if (b_zero) special_res = bus.op[1] ? bus.a : ALL_ONES;
    else        special_res = bus.op[1] ? '0 : bus.a;
  end

  // One multiply step: acc = {partial_high, remaining_multiplier}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // One divide step: acc = {remainder, dividend/quotient}.
  logic [WIDTH:0]     rem_sh, trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    trial    = rem_sh - {1'b0, dsr_q};
    div_ok   = ~trial[WIDTH];
    div_next = {(div_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                acc_q[WIDTH-2:0], div_ok};
  end

  // Sign fix-up and result selection.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_raw, div_fix, mul_res, fix_res;

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    div_raw  = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    div_fix  = neg_q ? (~div_raw + 1'b1) : div_raw;
    mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    fix_res  = op_q[2] ? div_fix : mul_res;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dsr_d   = dsr_q;
    out_d   = out_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          if (special) begin
            out_d   = special_res;
            zero_d  = (special_res == '0);
            state_d = S_DONE;
          end else begin
            // Remainder takes the dividend's sign; everything else the XOR.
            neg_d   = (bus.op[2] && bus.op[1]) ? sa : (sa ^ sb);
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            dsr_d   = b_mag;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        out_d   = fix_res;
        zero_d  = (fix_res == '0);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      dsr_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out       = out_q;
  assign bus.zero_flag = zero_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG  = 32'h8000_0000;
  localparam logic [W-1:0] ALL_ONES = 32'hFFFF_FFFF;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [2:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint       sa_l, sb_l, ub_l, q_l;
    logic [63:0]  p;
    logic [W-1:0] r;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    ub_l = longint'({32'b0, b});
    r    = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = sa_l * sb_l;             r = p[63:32]; end
      3'd2: begin p = sa_l * ub_l;             r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: if (b == 0) r = ALL_ONES;
            else begin q_l = sa_l / sb_l; p = q_l; r = p[31:0]; end
      3'd5: r = (b == 0) ? ALL_ONES : a / b;
      3'd6: if (b == 0) r = a;
            else begin q_l = sa_l % sb_l; p = q_l; r = p[31:0]; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Edges after the accept edge until out_valid is seen. Divide-by-zero and
  // signed-overflow cases land in DONE on the accept edge itself.
  function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (op[2] && b == 0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == ALL_ONES) return 0;
    return W + 1;
  endfunction

  // Driver: issue one request, check result, optional backpressure, hand off.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] exp_v;
    int lat;
    exp_q.push_back(ref_result(op, a, b));
    @(negedge clk);
    check("in_ready_idle", {31'b0, bus.in_ready}, 1);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.a  = $urandom;
    bus.b  = $urandom;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, ref_latency(op, a, b));
    exp_v = exp_q.pop_front();
    check("out", bus.out, exp_v);
    check("zero_flag", {31'b0, bus.zero_flag}, {31'b0, exp_v == 0});
    check("in_ready_done", {31'b0, bus.in_ready}, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 3'($urandom_range(0, 7));
      bus.a  = $urandom;
      @(posedge clk); #1;
      check("hold_out", bus.out, exp_v);
      check("hold_valid", {31'b0, bus.out_valid}, 1);
      check("hold_in_ready", {31'b0, bus.in_ready}, 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_valid", {31'b0, bus.out_valid}, 0);
    check("handoff_ready", {31'b0, bus.in_ready}, 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]   r_op;
    logic [W-1:0] r_a, r_b;
    int           sel;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    #12;
    check("rst_in_ready", {31'b0, bus.in_ready}, 1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 0);
    check("rst_out", bus.out, 0);
    check("rst_zero", {31'b0, bus.zero_flag}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply group
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd1, MIN_NEG, MIN_NEG, 0);
    run_op(3'd3, MIN_NEG, MIN_NEG, 0);
    run_op(3'd2, ALL_ONES, ALL_ONES, 0);
    // Divide group
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    // Special cases
    run_op(3'd5, 32'd123, 32'd0, 0);
    run_op(3'd6, 32'd123, 32'd0, 0);
    run_op(3'd4, MIN_NEG, ALL_ONES, 0);
    run_op(3'd6, MIN_NEG, ALL_ONES, 0);
    // Backpressure with in_valid pulsed while DONE
    run_op(3'd0, 32'd6, 32'd7, 5);
    run_op(3'd5, 32'd100, 32'd7, 0);

    // Reset mid-operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 3'd4;
    bus.a  = 32'd1000;
    bus.b  = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'b0, bus.in_ready}, 1);
    check("midrst_out_valid", {31'b0, bus.out_valid}, 0);
    check("midrst_out", bus.out, 0);
    check("midrst_zero", {31'b0, bus.zero_flag}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd6, 32'd7, 0);

    // Randomized operations with corner operands mixed in
    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      sel  = $urandom_range(0, 9);
      case (sel)
        0:       r_b = '0;
        1:       begin r_a = MIN_NEG; r_b = ALL_ONES; end
        2:       r_b = 32'($urandom_range(1, 15));
        3:       r_b = ALL_ONES;
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M funct3 operation set. It is the multi-cycle companion to the single-cycle integer ALU.
- It sits beside the ALU in the execute stage. The pipeline stalls on a valid/ready handshake while an operation is in flight.
- One operation is in flight at a time.
- It uses a shift-add multiplier and a restoring divider, both processing one bit per clock.

Parameters:
- WIDTH, 32: operand and result width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH+1): width of the internal step counter; derived, do not override.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit idle and able to accept a request.
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  rs1 operand.
- b  input  WIDTH  rs2 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- zero_flag  output  1  out == 0, valid whenever out_valid is high.

Behaviour:
- Reset (async, rst_n low):
  - state is IDLE; in_ready=1, out_valid=0, out=0, zero_flag=1.
  - All internal registers, including the counter, are cleared.
  - Reset in any state aborts the operation with no result produced.
- State IDLE:
  - in_ready=1.
  - An accept occurs on an edge where in_valid && in_ready. op, a and b are captured at that edge; inputs are don't-care afterwards.
- Signedness per op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - All other ops: unsigned.
  - MUL uses the low half of the product, so signedness does not affect it.
- Operand preparation at accept:
  - Signed operands are converted to magnitudes.
  - The result sign is recorded: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Special cases, decided at the accept edge. The unit goes straight to DONE; out_valid is high after 1 edge.
  - b==0 for DIV/DIVU: out = all ones.
  - b==0 for REM/REMU: out = a.
  - Signed overflow, DIV with a = 1<<(WIDTH-1) and b = all ones: out = a.
  - Signed overflow, REM with the same operands: out = 0.
- State CALC:
  - Counter is loaded with WIDTH at accept.
  - Each edge performs one step and decrements the counter.
  - Multiply step: if multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator, then shift right by 1.
  - Divide step: shift the {remainder, dividend} pair left by 1; trial-subtract the divisor from the remainder; keep the result if non-negative and shift in quotient bit 1, else 0.
  - When the counter reaches 0, go to state FIX.
- State FIX (one edge):
  - Apply the recorded sign by two's-complement negation of the 2*WIDTH product, the quotient or the remainder.
  - Select the output half: MUL takes the low WIDTH bits; MULH/MULHSU/MULHU take the high WIDTH bits.
  - Register out and zero_flag, then go to DONE.
- Latency: normal ops raise out_valid exactly WIDTH+1 edges after the accept edge (33 for WIDTH=32).
- State DONE:
  - out_valid=1 and in_ready=0.
  - out and zero_flag hold stable until an edge with out_ready=1; that edge returns the unit to IDLE and drops out_valid.
  - No same-cycle back-to-back: a new request is accepted no earlier than the edge after the handoff.
- in_ready is low in CALC, FIX and DONE; in_valid is ignored there.
- All arithmetic is modulo 2^WIDTH, or 2^(2*WIDTH) for the product. No overflow flags.

Test Plan (WIDTH=32):
- MUL a=7, b=-3 (0xFFFFFFFD) -> out=0xFFFFFFEB, out_valid exactly 33 edges after accept, zero_flag=0.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU with the same operands -> 0x40000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2.
- DIVU a=123, b=0 -> 0xFFFFFFFF. REM a=123, b=0 -> 123. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0 with zero_flag=1. All four have out_valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> out stable and in_ready=0 throughout. in_valid pulsed during that time is not accepted. Raise out_ready -> IDLE on the next edge.
- Reset mid-operation: assert rst_n=0 asynchronously 10 cycles into a DIV -> in_ready=1, out_valid=0 and out=0 immediately. A subsequent MUL 6*7 completes with out=42.
